udma_hyper_rx_pack: RTL

- RX-side counterpart of the TX prefetch FIFO in the uDMA HyperBus wrapper.
- Takes 16-bit beats from the HyperBus read datapath (valid/ready) and packs them into 32-bit uDMA RX words according to the configured datasize.
- Buffers packed words in a small FIFO, then delivers them to the uDMA RX channel (valid/ready).
- Marks the final word of a transfer and pulses an end-of-transfer event when that word leaves the FIFO.

---
 rtl/udma_hyper_rx_pack.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/udma_hyper_rx_pack.sv
// Packs 16-bit HyperBus read beats into 32-bit uDMA RX words (byte/halfword/word)
// and buffers them in a small FIFO carrying a per-word last flag.
module udma_hyper_rx_pack #(
    parameter int BUFFER_DEPTH = 4,
    parameter int CNT_W        = $clog2(BUFFER_DEPTH + 1)
) (
    input  logic             sys_clk_i,
    input  logic             rstn_i,
    input  logic             clr_i,
    input  logic [1:0]       cfg_datasize_i,
    input  logic [15:0]      in_data_i,
    input  logic             in_valid_i,
    input  logic             in_last_i,
    output logic             in_ready_o,
    output logic [31:0]      out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             out_last_o,
    output logic             evt_eot_o,
    output logic [CNT_W-1:0] fill_o
);

    localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HALF  = 2'd1,
        S_BYTE1 = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [15:0]        hold_q, hold_d;
    logic               blast_q, blast_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic               evt_q;
    logic [32:0]        mem_q [BUFFER_DEPTH];

    logic               full;
    logic               accept;
    logic               push;
    logic               pop;
    logic [32:0]        push_entry;
    logic [32:0]        head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full = (count_q == CNT_W'(BUFFER_DEPTH));
    // Ready is forced low during reset and flush so no beat is handshaken and then dropped.
    assign in_ready_o = rstn_i && !clr_i && !full && (state_q != S_BYTE1);
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        blast_d    = blast_q;
        push       = 1'b0;
        push_entry = '0;
        unique case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    unique case (cfg_datasize_i)
                        2'd0: begin
                            push       = 1'b1;
                            push_entry = {1'b0, 24'h0, in_data_i[7:0]};
                            hold_d     = in_data_i;
                            blast_d    = in_last_i;
                            state_d    = S_BYTE1;
                        end
                        2'd1: begin
                            push       = 1'b1;
                            push_entry = {in_last_i, 16'h0, in_data_i};
                        end
                        default: begin
                            if (in_last_i) begin
                                push       = 1'b1;
                                push_entry = {1'b1, 16'h0, in_data_i};
                            end else begin
                                hold_d  = in_data_i;
                                state_d = S_HALF;
                            end
                        end
                    endcase
                end
            end
            S_HALF: begin
                if (accept) begin
                    push       = 1'b1;
                    push_entry = {in_last_i, in_data_i, hold_q};
                    state_d    = S_EMPTY;
                end
            end
            S_BYTE1: begin
                // The high byte drains on its own once there is room; no input handshake.
                if (!full && !clr_i) begin
                    push       = 1'b1;
                    push_entry = {blast_q, 24'h0, hold_q[15:8]};
                    state_d    = S_EMPTY;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    assign head = mem_q[rd_ptr_q];
    assign pop  = (count_q != '0) && out_ready_i && !clr_i;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= S_EMPTY;
            hold_q   <= '0;
            blast_q  <= 1'b0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            evt_q    <= 1'b0;
        end else if (clr_i) begin
            state_q  <= S_EMPTY;
            hold_q   <= '0;
            blast_q  <= 1'b0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            evt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            blast_q <= blast_d;
            count_q <= count_d;
            evt_q   <= pop && head[32];
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge sys_clk_i) begin
        if (push && !clr_i) mem_q[wr_ptr_q] <= push_entry;
    end

    assign out_valid_o = (count_q != '0);
    assign out_data_o  = out_valid_o ? head[31:0] : 32'h0;
    assign out_last_o  = out_valid_o && head[32];
    assign evt_eot_o   = evt_q;
    assign fill_o      = count_q;

endmodule
